// File: rtl/mmi_pkg.sv
// Shared definitions for the CPU-side register bank in front of mmi_to_cp:
// register word offsets, CTRL/STAT bit positions, control-word field layout
// and a byte-lane merge helper.
package mmi_pkg;

   // Register word offsets inside the window
   typedef enum logic [1:0] {
      REG_CFG0 = 2'd0,
      REG_CFG1 = 2'd1,
      REG_STAT = 2'd2,
      REG_CTRL = 2'd3
   } reg_word_e;

   // CTRL bit positions
   localparam int unsigned CTRL_IRQ_EN_BIT   = 0;
   localparam int unsigned CTRL_IRQ_PEND_BIT = 1;
   localparam int unsigned CTRL_ABORT_BIT    = 2;

   // STAT bit positions (stat_q occupies [23:0])
   localparam int unsigned STAT_Q_W          = 24;
   localparam int unsigned STAT_BUSY_BIT     = 24;
   localparam int unsigned STAT_PEND_BIT     = 25;
   localparam int unsigned STAT_ERR_BIT      = 26;

   // Control word layout toward mmi_to_cp
   localparam int unsigned CTRL_DATA_LSB     = 0;
   localparam int unsigned CTRL_DATA_W       = 8;
   localparam int unsigned CTRL_CMD_LSB      = 8;
   localparam int unsigned CTRL_CMD_W        = 8;
   localparam int unsigned CTRL_TH_LSB       = 16;
   localparam int unsigned CTRL_TH_W         = 16;
   localparam int unsigned CTRL_SRC_LSB      = 32;
   localparam int unsigned CTRL_SRC_W        = 16;
   localparam int unsigned CTRL_DEST_LSB     = 48;
   localparam int unsigned CTRL_DEST_W       = 16;

   // Replace only the bytes whose lane enable is set
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  strb);
      logic [31:0] res;
      res = old_word;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) begin
            res[8*b +: 8] = new_word[8*b +: 8];
         end else begin
            res[8*b +: 8] = old_word[8*b +: 8];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/mmi_irq_ctrl.sv
// Completion interrupt: rising-edge detect on the registered done bit,
// sticky pending flag with write-1-to-clear, and an enable gate.
module mmi_irq_ctrl (
   input  logic clk,
   input  logic rst_n,
   input  logic done,
   input  logic w1c,
   input  logic en_we,
   input  logic en_wdata,
   output logic irq_pending,
   output logic irq_en,
   output logic irq
);

   logic done_prev_r;
   logic pending_r;
   logic en_r;
   logic rise_s;

   assign rise_s      = done & ~done_prev_r;
   assign irq_pending = pending_r;
   assign irq_en      = en_r;
   assign irq         = pending_r & en_r;

   // Track done history, latch completion events (set beats clear), hold enable
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_prev_r <= 1'b0;
         pending_r   <= 1'b0;
         en_r        <= 1'b0;
      end else begin
         done_prev_r <= done;
         if (rise_s) begin
            pending_r <= 1'b1;
         end else if (w1c) begin
            pending_r <= 1'b0;
         end
         if (en_we) begin
            en_r <= en_wdata;
         end
      end
   end

endmodule

// File: rtl/mmi_cp_regs.sv
// CPU register bank feeding mmi_to_cp: holds command fields, issues each
// command once over valid/ready, flags colliding writes, mirrors status and
// raises a completion interrupt.
module mmi_cp_regs
   import mmi_pkg::*;
#(
   parameter int unsigned ADDR_W   = 2,
   parameter int unsigned DONE_BIT = 0,
   parameter int unsigned BUSY_BIT = 1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_we,
   input  logic              i_re,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [31:0]       i_wdata,
   input  logic [3:0]        i_wstrb,
   output logic [31:0]       o_rdata,
   output logic              o_rvalid,
   output logic [63:0]       o_mmi_ctrl,
   input  logic [23:0]       i_mmi_stat,
   output logic              o_cmd_valid,
   input  logic              i_cmd_ready,
   output logic              o_irq
);

   logic [31:0] cfg0_r;
   logic [31:0] cfg1_r;
   logic        pending_r;
   logic        err_r;
   logic [23:0] stat_q_r;
   logic [31:0] rdata_r;
   logic        rvalid_r;

   reg_word_e   word_s;
   logic        mapped_s;
   logic        wr_cfg0_s;
   logic        wr_cfg1_s;
   logic        wr_ctrl_s;
   logic        collide_s;
   logic        issue_s;
   logic        accept_s;
   logic        abort_s;
   logic        irq_w1c_s;
   logic        irq_pending_s;
   logic        irq_en_s;
   logic [31:0] rd_mux_s;
   logic [63:0] ctrl_word_s;

   assign word_s   = reg_word_e'(i_addr[1:0]);
   assign mapped_s = (i_addr >> 2) == {ADDR_W{1'b0}};

   // Decode bus writes into per-register strobes and command events
   always_comb begin
      wr_cfg0_s = 1'b0;
      wr_cfg1_s = 1'b0;
      wr_ctrl_s = 1'b0;
      if (i_we && mapped_s) begin
         case (word_s)
            REG_CFG0: wr_cfg0_s = 1'b1;
            REG_CFG1: wr_cfg1_s = 1'b1;
            REG_CTRL: wr_ctrl_s = 1'b1;
            default:  wr_ctrl_s = 1'b0;
         endcase
      end else begin
         wr_ctrl_s = 1'b0;
      end
      // Field writes during an outstanding command are dropped whole
      collide_s = (wr_cfg0_s | wr_cfg1_s) & pending_r;
      issue_s   = wr_cfg0_s & ~pending_r & i_wstrb[1] & (i_wdata[15:8] != 8'h00);
      accept_s  = pending_r & i_cmd_ready;
      abort_s   = wr_ctrl_s & i_wstrb[0] & i_wdata[CTRL_ABORT_BIT];
      irq_w1c_s = wr_ctrl_s & i_wstrb[0] & i_wdata[CTRL_IRQ_PEND_BIT];
   end

   // Hold command fields; they only change while no command is outstanding
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cfg0_r <= 32'h0;
         cfg1_r <= 32'h0;
      end else begin
         if (wr_cfg0_s && !pending_r) begin
            cfg0_r <= merge_bytes(cfg0_r, i_wdata, i_wstrb);
         end
         if (wr_cfg1_s && !pending_r) begin
            cfg1_r <= merge_bytes(cfg1_r, i_wdata, i_wstrb);
         end
      end
   end

   // Command pending / sticky collision error; abort overrides everything
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pending_r <= 1'b0;
         err_r     <= 1'b0;
      end else if (abort_s) begin
         pending_r <= 1'b0;
         err_r     <= 1'b0;
      end else begin
         if (collide_s) begin
            err_r <= 1'b1;
         end
         if (issue_s) begin
            pending_r <= 1'b1;
         end else if (accept_s) begin
            pending_r <= 1'b0;
         end
      end
   end

   // One register stage on the coprocessor status word
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         stat_q_r <= 24'h0;
      end else begin
         stat_q_r <= i_mmi_stat;
      end
   end

   // Select read data for the addressed word; unmapped words read as zero
   always_comb begin
      rd_mux_s = 32'h0;
      if (mapped_s) begin
         case (word_s)
            REG_CFG0: rd_mux_s = cfg0_r;
            REG_CFG1: rd_mux_s = cfg1_r;
            REG_STAT: begin
               rd_mux_s[STAT_Q_W-1:0]  = stat_q_r;
               rd_mux_s[STAT_BUSY_BIT] = stat_q_r[8+BUSY_BIT];
               rd_mux_s[STAT_PEND_BIT] = pending_r;
               rd_mux_s[STAT_ERR_BIT]  = err_r;
            end
            REG_CTRL: begin
               rd_mux_s[CTRL_IRQ_EN_BIT]   = irq_en_s;
               rd_mux_s[CTRL_IRQ_PEND_BIT] = irq_pending_s;
            end
            default:  rd_mux_s = 32'h0;
         endcase
      end else begin
         rd_mux_s = 32'h0;
      end
   end

   // Registered read port with fixed one-cycle latency
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rdata_r  <= 32'h0;
         rvalid_r <= 1'b0;
      end else begin
         rvalid_r <= i_re;
         if (i_re) begin
            rdata_r <= rd_mux_s;
         end else begin
            rdata_r <= 32'h0;
         end
      end
   end

   // Assemble control word; the command byte is shown only while pending
   always_comb begin
      ctrl_word_s = 64'h0;
      ctrl_word_s[CTRL_DATA_LSB +: CTRL_DATA_W] = cfg0_r[7:0];
      ctrl_word_s[CTRL_TH_LSB   +: CTRL_TH_W]   = cfg0_r[31:16];
      ctrl_word_s[CTRL_SRC_LSB  +: CTRL_SRC_W]  = cfg1_r[15:0];
      ctrl_word_s[CTRL_DEST_LSB +: CTRL_DEST_W] = cfg1_r[31:16];
      if (pending_r) begin
         ctrl_word_s[CTRL_CMD_LSB +: CTRL_CMD_W] = cfg0_r[15:8];
      end else begin
         ctrl_word_s[CTRL_CMD_LSB +: CTRL_CMD_W] = 8'h00;
      end
   end

   mmi_irq_ctrl u_irq (
      .clk         (i_clk),
      .rst_n       (i_rst_n),
      .done        (stat_q_r[8+DONE_BIT]),
      .w1c         (irq_w1c_s),
      .en_we       (wr_ctrl_s & i_wstrb[0]),
      .en_wdata    (i_wdata[CTRL_IRQ_EN_BIT]),
      .irq_pending (irq_pending_s),
      .irq_en      (irq_en_s),
      .irq         (o_irq)
   );

   assign o_rdata     = rdata_r;
   assign o_rvalid    = rvalid_r;
   assign o_mmi_ctrl  = ctrl_word_s;
   assign o_cmd_valid = pending_r;

endmodule

// File: tb/tb_mmi_cp_regs.sv
// Bench for mmi_cp_regs: directed scenarios plus random bus traffic, checked
// against a register-level reference model. Reads go through a scoreboard
// queue popped by a monitor whenever o_rvalid is seen.
module tb_mmi_cp_regs;

   localparam int AW = 3;

   logic          i_clk = 1'b0;
   logic          i_rst_n = 1'b0;
   logic          i_we = 1'b0;
   logic          i_re = 1'b0;
   logic [AW-1:0] i_addr = '0;
   logic [31:0]   i_wdata = 32'h0;
   logic [3:0]    i_wstrb = 4'h0;
   logic [31:0]   o_rdata;
   logic          o_rvalid;
   logic [63:0]   o_mmi_ctrl;
   logic [23:0]   i_mmi_stat = 24'h0;
   logic          o_cmd_valid;
   logic          i_cmd_ready = 1'b0;
   logic          o_irq;

   mmi_cp_regs #(.ADDR_W(AW), .DONE_BIT(0), .BUSY_BIT(1)) dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_we        (i_we),
      .i_re        (i_re),
      .i_addr      (i_addr),
      .i_wdata     (i_wdata),
      .i_wstrb     (i_wstrb),
      .o_rdata     (o_rdata),
      .o_rvalid    (o_rvalid),
      .o_mmi_ctrl  (o_mmi_ctrl),
      .i_mmi_stat  (i_mmi_stat),
      .o_cmd_valid (o_cmd_valid),
      .i_cmd_ready (i_cmd_ready),
      .o_irq       (o_irq)
   );

   always #5 i_clk = ~i_clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // Reference model state
   logic [31:0] m_cfg0 = 32'h0, m_cfg1 = 32'h0;
   logic        m_pend = 1'b0, m_err = 1'b0, m_ipend = 1'b0, m_ien = 1'b0;
   logic [23:0] m_stat = 24'h0;
   logic        m_done_prev = 1'b0;

   typedef struct {
      logic [31:0] data;
      int          cyc;
   } rd_t;
   rd_t sb[$];

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic logic [31:0] lanes(logic [31:0] old_w, logic [31:0] new_w, logic [3:0] s);
      logic [31:0] r;
      r = old_w;
      for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = new_w[8*b +: 8];
      return r;
   endfunction

   function automatic logic [63:0] exp_ctrl();
      return {m_cfg1, m_cfg0[31:16], (m_pend ? m_cfg0[15:8] : 8'h00), m_cfg0[7:0]};
   endfunction

   function automatic logic [31:0] exp_read(logic [AW-1:0] a);
      case (a)
         3'd0:    return m_cfg0;
         3'd1:    return m_cfg1;
         3'd2:    return {5'd0, m_err, m_pend, m_stat[9], m_stat};
         3'd3:    return {30'd0, m_ipend, m_ien};
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_reset();
      m_cfg0 = 32'h0; m_cfg1 = 32'h0; m_pend = 1'b0; m_err = 1'b0;
      m_ipend = 1'b0; m_ien = 1'b0; m_stat = 24'h0; m_done_prev = 1'b0;
   endtask

   // Advance one clock with the currently driven inputs, stepping the model
   task automatic cycle();
      logic [31:0] n_c0, n_c1;
      logic        n_pend, n_err, n_ipend, n_ien, rise;
      if (i_re) sb.push_back('{exp_read(i_addr), cyc});
      n_c0 = m_cfg0; n_c1 = m_cfg1; n_pend = m_pend; n_err = m_err;
      n_ipend = m_ipend; n_ien = m_ien;
      rise = m_stat[8] && !m_done_prev;
      if (m_pend && i_cmd_ready) n_pend = 1'b0;
      if (i_we && i_addr < 4) begin
         if (i_addr == 0 || i_addr == 1) begin
            if (m_pend) n_err = 1'b1;
            else if (i_addr == 0) begin
               n_c0 = lanes(m_cfg0, i_wdata, i_wstrb);
               if (i_wstrb[1] && i_wdata[15:8] != 8'h00) n_pend = 1'b1;
            end else n_c1 = lanes(m_cfg1, i_wdata, i_wstrb);
         end else if (i_addr == 3 && i_wstrb[0]) begin
            n_ien = i_wdata[0];
            if (i_wdata[1]) n_ipend = 1'b0;
            if (i_wdata[2]) begin n_pend = 1'b0; n_err = 1'b0; end
         end
      end
      if (rise) n_ipend = 1'b1;
      @(posedge i_clk);
      m_cfg0 = n_c0; m_cfg1 = n_c1; m_pend = n_pend; m_err = n_err;
      m_ipend = n_ipend; m_ien = n_ien;
      m_done_prev = m_stat[8]; m_stat = i_mmi_stat;
      cyc++;
      @(negedge i_clk);
   endtask

   task automatic wr(logic [AW-1:0] a, logic [31:0] d, logic [3:0] s);
      i_we = 1'b1; i_addr = a; i_wdata = d; i_wstrb = s;
      cycle();
      i_we = 1'b0; i_wstrb = 4'h0;
   endtask

   task automatic rd(logic [AW-1:0] a);
      i_re = 1'b1; i_addr = a;
      cycle();
      i_re = 1'b0;
   endtask

   task automatic idle(int n);
      for (int k = 0; k < n; k++) cycle();
   endtask

   // Monitor: pop the scoreboard on each read response, track live outputs
   always @(negedge i_clk) begin
      if (o_rvalid) begin
         if (sb.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL rd_unexpected: got rvalid with data %h, expected no response", o_rdata);
         end else begin
            rd_t e;
            e = sb.pop_front();
            chk("rdata", {32'h0, o_rdata}, {32'h0, e.data});
            chk("rd_latency", cyc, e.cyc + 1);
         end
      end
      chk("mmi_ctrl", o_mmi_ctrl, exp_ctrl());
      chk("cmd_valid", o_cmd_valid, m_pend);
      chk("irq", o_irq, m_ipend & m_ien);
   end

   initial begin
      repeat (2) @(negedge i_clk);
      i_rst_n = 1'b1;
      rd(3'd2);
      idle(1);

      // Issue and hold
      wr(3'd1, 32'h2000_1000, 4'hF);
      wr(3'd0, 32'h0300_05AA, 4'hF);
      chk("issue_ctrl", o_mmi_ctrl, 64'h2000_1000_0300_05AA);
      chk("issue_valid", o_cmd_valid, 1'b1);
      idle(5);
      chk("hold_ctrl", o_mmi_ctrl, 64'h2000_1000_0300_05AA);
      i_cmd_ready = 1'b1;
      cycle();
      i_cmd_ready = 1'b0;
      chk("accept_valid", o_cmd_valid, 1'b0);
      chk("accept_cmd_byte", o_mmi_ctrl[15:8], 8'h00);

      // Collision and abort
      wr(3'd0, 32'h0300_05AA, 4'hF);
      wr(3'd0, 32'h0000_0111, 4'hF);
      chk("collide_ctrl", o_mmi_ctrl, 64'h2000_1000_0300_05AA);
      rd(3'd2);
      wr(3'd3, 32'h0000_0004, 4'hF);
      chk("abort_valid", o_cmd_valid, 1'b0);
      rd(3'd2);

      // Byte lanes
      wr(3'd0, 32'hFFFF_FFFF, 4'b0001);
      chk("lane_valid", o_cmd_valid, 1'b0);
      chk("lane_data", o_mmi_ctrl[7:0], 8'hFF);
      rd(3'd0);

      // IRQ edge, set-beats-clear, plain clear
      wr(3'd3, 32'h0000_0001, 4'h1);
      i_mmi_stat = 24'h000100;
      cycle();
      chk("irq_early", o_irq, 1'b0);
      cycle();
      chk("irq_set", o_irq, 1'b1);
      i_mmi_stat = 24'h000000;
      idle(2);
      i_mmi_stat = 24'h000100;
      cycle();
      wr(3'd3, 32'h0000_0003, 4'h1);
      chk("irq_set_wins", o_irq, 1'b1);
      wr(3'd3, 32'h0000_0003, 4'h1);
      chk("irq_w1c", o_irq, 1'b0);

      // Unmapped address
      wr(3'd5, 32'hFFFF_FFFF, 4'hF);
      rd(3'd5);
      rd(3'd0);

      // Asynchronous reset mid-command
      i_mmi_stat = 24'h000000;
      idle(2);
      i_mmi_stat = 24'h000100;
      wr(3'd0, 32'h0400_0011, 4'hF);
      idle(2);
      rd(3'd2);
      #2;
      i_rst_n = 1'b0;
      model_reset();
      #1;
      chk("rst_ctrl", o_mmi_ctrl, 64'h0);
      chk("rst_valid", o_cmd_valid, 1'b0);
      chk("rst_irq", o_irq, 1'b0);
      chk("rst_rvalid", o_rvalid, 1'b0);
      chk("rst_rdata", o_rdata, 32'h0);
      i_mmi_stat = 24'h000000;
      repeat (2) @(negedge i_clk);
      i_rst_n = 1'b1;
      rd(3'd2);
      idle(1);
      chk("no_replay", o_cmd_valid, 1'b0);

      // Random traffic
      for (int t = 0; t < 600; t++) begin
         i_we        = ($urandom_range(0, 2) == 0);
         i_re        = ($urandom_range(0, 1) == 1);
         i_addr      = AW'($urandom_range(0, 7));
         i_wdata     = $urandom;
         i_wstrb     = 4'($urandom);
         i_cmd_ready = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 3) == 0) i_mmi_stat = 24'($urandom);
         if (i_addr == 3'd3 && $urandom_range(0, 3) != 0) i_wdata[2] = 1'b0;
         cycle();
      end
      i_we = 1'b0; i_re = 1'b0; i_cmd_ready = 1'b0;
      idle(3);
      chk("sb_drain", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
